// File: rtl/vga_pkg.sv
// Shared raster constants for the VGA timing generator and its address consumer.
// Default segment lengths describe 800x600@60 from a 40 MHz pixel clock.
package vga_pkg;

  localparam int unsigned H_VIS_DEF  = 800;
  localparam int unsigned H_FP_DEF   = 40;
  localparam int unsigned H_SYNC_DEF = 128;
  localparam int unsigned H_BP_DEF   = 88;
  localparam int unsigned H_TOTAL    = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int unsigned V_VIS_DEF  = 600;
  localparam int unsigned V_FP_DEF   = 1;
  localparam int unsigned V_SYNC_DEF = 4;
  localparam int unsigned V_BP_DEF   = 23;
  localparam int unsigned V_TOTAL    = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int unsigned H_CNT_W = $clog2(H_TOTAL);
  localparam int unsigned V_CNT_W = $clog2(V_TOTAL);

  localparam int unsigned SCALE_SHIFT_DEF = 2;
  localparam int unsigned POS_W = 9;
  // Scaled playfield; vga_add uses FB_W as its row stride.
  localparam int unsigned FB_W = H_VIS_DEF >> SCALE_SHIFT_DEF;
  localparam int unsigned FB_H = V_VIS_DEF >> SCALE_SHIFT_DEF;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic visible;
    logic line_start;
    logic frame_start;
  } vga_ctl_t;

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping raster axis counter: counts 0..MAX while inc is high, flags the wrap cycle.
module vga_axis_counter #(
  parameter int unsigned MAX   = 1055,
  parameter int unsigned WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  assign wrap = inc && (cnt_q == MaxVal);
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (wrap) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_timing.sv
// Free-running VGA raster generator: sync, visible window, strobes and down-scaled position.
// Define VGA_RAM_ALIGN_EN to delay the control outputs one more cycle to match a framebuffer read.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_VIS       = H_VIS_DEF,
  parameter int unsigned H_FP        = H_FP_DEF,
  parameter int unsigned H_SYNC      = H_SYNC_DEF,
  parameter int unsigned H_BP        = H_BP_DEF,
  parameter int unsigned V_VIS       = V_VIS_DEF,
  parameter int unsigned V_FP        = V_FP_DEF,
  parameter int unsigned V_SYNC      = V_SYNC_DEF,
  parameter int unsigned V_BP        = V_BP_DEF,
  parameter bit          HS_POL      = 1'b1,
  parameter bit          VS_POL      = 1'b1,
  parameter int unsigned SCALE_SHIFT = SCALE_SHIFT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  output logic             hsync,
  output logic             vsync,
  output logic             visible,
  output logic [POS_W-1:0] posx,
  output logic [POS_W-1:0] posy,
  output logic             line_start,
  output logic             frame_start
);

  localparam int unsigned HTot    = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTot    = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(HTot);
  localparam int unsigned VW      = $clog2(VTot);
  localparam int unsigned HsStart = H_VIS + H_FP;
  localparam int unsigned HsEnd   = H_VIS + H_FP + H_SYNC;
  localparam int unsigned VsStart = V_VIS + V_FP;
  localparam int unsigned VsEnd   = V_VIS + V_FP + V_SYNC;

  localparam vga_ctl_t CtlIdle = '{
    hsync:       !HS_POL,
    vsync:       !VS_POL,
    visible:     1'b0,
    line_start:  1'b0,
    frame_start: 1'b0
  };

  if (((H_VIS - 1) >> SCALE_SHIFT) > 511) begin : g_hscale_chk
    $error("vga_timing: scaled x range exceeds 9 bits");
  end
  if (((V_VIS - 1) >> SCALE_SHIFT) > 511) begin : g_vscale_chk
    $error("vga_timing: scaled y range exceeds 9 bits");
  end

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          h_wrap;
  logic          unused_v_wrap;

  vga_axis_counter #(
    .MAX   (HTot - 1),
    .WIDTH (HW)
  ) u_hcnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (1'b1),
    .cnt  (hcnt),
    .wrap (h_wrap)
  );

  vga_axis_counter #(
    .MAX   (VTot - 1),
    .WIDTH (VW)
  ) u_vcnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (h_wrap),
    .cnt  (vcnt),
    .wrap (unused_v_wrap)
  );

  // Widen once so every window compare is a plain 32-bit unsigned compare.
  logic [31:0] h32, v32;
  assign h32 = 32'(hcnt);
  assign v32 = 32'(vcnt);

  vga_ctl_t         ctl_d, ctl_q;
  logic [POS_W-1:0] posx_d, posx_q;
  logic [POS_W-1:0] posy_d, posy_q;

  always_comb begin
    ctl_d  = CtlIdle;
    posx_d = '0;
    posy_d = '0;

    ctl_d.visible     = (h32 < H_VIS) && (v32 < V_VIS);
    ctl_d.hsync       = ((h32 >= HsStart) && (h32 < HsEnd)) ? HS_POL : !HS_POL;
    ctl_d.vsync       = ((v32 >= VsStart) && (v32 < VsEnd)) ? VS_POL : !VS_POL;
    ctl_d.line_start  = (h32 == 32'd0);
    ctl_d.frame_start = (h32 == 32'd0) && (v32 == 32'd0);

    if (ctl_d.visible) begin
      posx_d = POS_W'(h32 >> SCALE_SHIFT);
      posy_d = POS_W'(v32 >> SCALE_SHIFT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_q  <= CtlIdle;
      posx_q <= '0;
      posy_q <= '0;
    end else begin
      ctl_q  <= ctl_d;
      posx_q <= posx_d;
      posy_q <= posy_d;
    end
  end

  vga_ctl_t ctl_out;

`ifdef VGA_RAM_ALIGN_EN
  // Position feeds the address path directly; only the controls wait for the RAM read.
  vga_ctl_t ctl_dly_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_dly_q <= CtlIdle;
    end else begin
      ctl_dly_q <= ctl_q;
    end
  end

  assign ctl_out = ctl_dly_q;
`else
  assign ctl_out = ctl_q;
`endif

  assign hsync       = ctl_out.hsync;
  assign vsync       = ctl_out.vsync;
  assign visible     = ctl_out.visible;
  assign line_start  = ctl_out.line_start;
  assign frame_start = ctl_out.frame_start;
  assign posx        = posx_q;
  assign posy        = posy_q;

endmodule
